// File: rtl/tiny1_pkg.sv
// tiny1_pkg: shared defaults, UART frame constants and the RX state type
// for the tiny1 board top and its receiver.
package tiny1_pkg;

  localparam int DEF_CLKS_PER_BIT = 104;
  localparam int DEF_LED_DIV      = 4096;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a two-flop input synchronizer. Emits a one-cycle
// rx_valid with the byte after a good stop bit; a low stop bit discards the
// byte and parks the FSM until the line returns high.
module uart_rx
  import tiny1_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  logic                 rxd_meta_q;
  logic                 rxd_sync_q;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;

  // Next-state logic: half-bit start check, then full-bit spaced samples.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    case (state_q)
      RX_IDLE: begin
        if (!rxd_sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == DATA_LAST) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_sync_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            state_d    = RX_IDLE;
          end else begin
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (rxd_sync_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchronizer and FSM registers; the line is assumed idle-high at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: rtl/tiny1_top.sv
// tiny1_top: board top. Free-running LED counter, UART receiver, a one-byte
// holding register and an 8N1 transmitter that echoes every good byte.
module tiny1_top
  import tiny1_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int LED_DIV      = DEF_LED_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic RXD,
  output logic TXD,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7,
  output logic LED8
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(LED_DIV);
  localparam int LW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] TX_BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(LED_DIV - 1);
  localparam logic [LW-1:0] TX_BITS_AFTER_START = LW'(FRAME_BITS - 1);

  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;

  logic [PW-1:0]        presc_q, presc_d;
  logic [DATA_BITS-1:0] led_q, led_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 txd_q, txd_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [LW-1:0]        tx_left_q, tx_left_d;
  logic [DATA_BITS:0]   tx_shift_q, tx_shift_d;
  logic                 tx_end;
  logic                 take;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst),
    .rxd     (RXD),
    .rx_valid(rx_valid),
    .rx_data (rx_data)
  );

  // The last cycle of the stop bit can hand straight over to the next frame,
  // so back-to-back echoes run at exactly the receive rate.
  assign tx_end = tx_busy_q && (tx_cnt_q == TX_BIT_LAST) && (tx_left_q == '0);
  assign take   = hold_full_q && (!tx_busy_q || tx_end);

  // LED counter: a received byte overrides the increment and restarts the prescaler.
  always_comb begin
    presc_d = presc_q;
    led_d   = led_q;
    if (rx_valid) begin
      led_d   = rx_data;
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      led_d   = led_q + 8'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Holding register: a byte arriving while it is still occupied is dropped.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (take) begin
      hold_full_d = 1'b0;
    end
    if (rx_valid && (!hold_full_q || take)) begin
      hold_full_d = 1'b1;
      hold_d      = rx_data;
    end
  end

  // Transmitter: start bit on take, then shift data LSB first followed by stop.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    txd_d      = txd_q;
    tx_cnt_d   = tx_cnt_q;
    tx_left_d  = tx_left_q;
    tx_shift_d = tx_shift_q;
    if (take) begin
      tx_busy_d  = 1'b1;
      txd_d      = 1'b0;
      tx_cnt_d   = '0;
      tx_left_d  = TX_BITS_AFTER_START;
      tx_shift_d = {1'b1, hold_q};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == TX_BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_left_q == '0) begin
          tx_busy_d = 1'b0;
          txd_d     = 1'b1;
        end else begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[DATA_BITS:1]};
          tx_left_d  = tx_left_q - LW'(1);
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end
  end

  // All top-level state; reset drives TXD high and the LEDs dark immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      led_q       <= '0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      tx_busy_q   <= 1'b0;
      txd_q       <= 1'b1;
      tx_cnt_q    <= '0;
      tx_left_q   <= '0;
      tx_shift_q  <= '1;
    end else begin
      presc_q     <= presc_d;
      led_q       <= led_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      tx_busy_q   <= tx_busy_d;
      txd_q       <= txd_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_left_q   <= tx_left_d;
      tx_shift_q  <= tx_shift_d;
    end
  end

  assign TXD  = txd_q;
  assign LED1 = led_q[0];
  assign LED2 = led_q[1];
  assign LED3 = led_q[2];
  assign LED4 = led_q[3];
  assign LED5 = led_q[4];
  assign LED6 = led_q[5];
  assign LED7 = led_q[6];
  assign LED8 = led_q[7];

endmodule

// File: tb/tb_tiny1_top.sv
// tb_tiny1_top: directed and randomized checks of the tiny1 board top with a
// shortened bit period and LED divider so the whole run stays short.
module tb_tiny1_top;

   localparam int CPB    = 8;
   localparam int DIV    = 100;
   localparam int MARGIN = 8;

   logic clk = 1'b0;
   logic rst;
   logic rxd;
   logic txd;
   logic led1, led2, led3, led4, led5, led6, led7, led8;
   logic [7:0] ledBus;

   int cyc = 0;
   int testsRun = 0;
   int testsFailed = 0;
   int resetEpoch = 0;
   int txBad = 0;
   int txFalls = 0;
   int refBase = 0;
   int refAnchor = 0;
   logic [7:0] txQueue[$];
   logic [7:0] expQueue[$];

   assign ledBus = {led8, led7, led6, led5, led4, led3, led2, led1};

   tiny1_top #(
      .CLKS_PER_BIT(CPB),
      .LED_DIV(DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .RXD (rxd),
      .TXD (txd),
      .LED1(led1),
      .LED2(led2),
      .LED3(led3),
      .LED4(led4),
      .LED5(led5),
      .LED6(led6),
      .LED7(led7),
      .LED8(led8)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Cycle counter that the LED model uses as its time base.
   always @(posedge clk) cyc <= cyc + 1;

   // Every falling TXD edge outside reset, so leftover frames after a reset show up.
   always @(negedge txd) begin
      if (rst) txFalls++;
   end

   // UART line monitor: decodes each TXD frame at mid-bit and queues the byte;
   // a frame overlapped by a reset is thrown away.
   initial begin : txMonitor
      int epoch;
      logic [7:0] data;
      logic ok;
      forever begin
         @(negedge txd);
         if (rst) begin
            epoch = resetEpoch;
            ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            if (txd !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               data[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            if (txd !== 1'b1) ok = 1'b0;
            if (epoch == resetEpoch) begin
               if (ok) txQueue.push_back(data);
               else txBad++;
            end
         end
      end
   end

   // One comparison: counts it, and counts and reports it when it does not hold.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one 8N1 frame starting at the current negedge; returns its start cycle.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, output int frameStart);
      frameStart = cyc;
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stopBit;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
   endtask

   // Sends a good frame and updates the model: LEDs take the byte about one
   // stop-sample after the start edge, and the byte should be echoed.
   task automatic sendByte(input logic [7:0] data);
      int s;
      applyStimulus(data, 1'b1, s);
      refBase   = int'(data);
      refAnchor = s + 2 + CPB / 2 + 9 * CPB + 1;
      expQueue.push_back(data);
   endtask

   // LED model: value at anchor plus whole divider periods since, modulo 256.
   // Waits until the model is well clear of an increment before comparing.
   task automatic checkLed(input string tag);
      int waited;
      int ph;
      waited = 0;
      ph = (cyc - refAnchor) % DIV;
      while ((ph < MARGIN || ph > DIV - MARGIN) && waited < 2 * DIV) begin
         @(negedge clk);
         waited++;
         ph = (cyc - refAnchor) % DIV;
      end
      checkOutput(tag, 32'(ledBus), 32'((refBase + (cyc - refAnchor) / DIV) % 256));
   endtask

   // Lets the transmitter drain, then compares echoed bytes against expectations.
   task automatic checkEcho(input string tag);
      logic [7:0] got;
      logic [7:0] want;
      repeat (12 * CPB) @(negedge clk);
      checkOutput({tag, "Count"}, txQueue.size(), expQueue.size());
      while (txQueue.size() > 0 && expQueue.size() > 0) begin
         got  = txQueue.pop_front();
         want = expQueue.pop_front();
         checkOutput({tag, "Byte"}, 32'(got), 32'(want));
      end
      txQueue.delete();
      expQueue.delete();
   endtask

   // Main directed sequence.
   initial begin : applyMain
      int changes;
      int waited;
      int fallsBefore;
      logic txLowSeen;
      logic [7:0] prevLed;
      logic [7:0] rnd;

      rst = 1'b1;
      rxd = 1'b1;
      #2;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("resetLed", 32'(ledBus), 32'h00);
      checkOutput("resetTxd", 32'(txd), 32'h1);

      rst = 1'b1;
      refBase = 0;
      refAnchor = cyc;
      repeat (DIV - 1) @(negedge clk);
      checkOutput("countBeforeFirst", 32'(ledBus), 32'h00);
      @(negedge clk);
      checkOutput("countFirst", 32'(ledBus), 32'h01);
      repeat (DIV) @(negedge clk);
      checkOutput("countSecond", 32'(ledBus), 32'h02);
      repeat (253 * DIV + DIV / 2) @(negedge clk);
      checkLed("countFF");
      repeat (DIV) @(negedge clk);
      checkLed("countWrap");
      checkOutput("countWrapZero", 32'(ledBus), 32'h00);

      rst = 1'b0;
      rxd = 1'b0;
      resetEpoch++;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      refBase = 0;
      refAnchor = cyc;
      changes = 0;
      txLowSeen = 1'b0;
      prevLed = ledBus;
      repeat (20 * DIV) begin
         @(negedge clk);
         if (ledBus !== prevLed) changes++;
         if (txd !== 1'b1) txLowSeen = 1'b1;
         prevLed = ledBus;
      end
      checkOutput("stuckChanges", changes, 20);
      checkOutput("stuckTxdLow", 32'(txLowSeen), 32'h0);
      checkOutput("stuckLed", 32'(ledBus), 32'd20);
      rxd = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      checkOutput("stuckNoEcho", txQueue.size(), 0);

      sendByte(8'hA5);
      checkLed("singleLoad");
      checkOutput("singleLoadA5", 32'(ledBus), 32'hA5);
      repeat (DIV) @(negedge clk);
      checkLed("singleInc");
      checkEcho("single");

      sendByte(8'h12);
      sendByte(8'h34);
      checkLed("b2bLed");
      checkEcho("b2b");

      rxd = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checkLed("glitchLed");
      begin
         int s;
         applyStimulus(8'h55, 1'b0, s);
      end
      repeat (2 * CPB) @(negedge clk);
      checkLed("framingLed");
      sendByte(8'h3C);
      checkLed("afterErrLed");
      checkEcho("afterErr");

      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
         rnd = 8'($urandom);
         sendByte(rnd);
         checkLed("randLed");
      end
      checkEcho("rand");

      sendByte(8'hFF);
      waited = 0;
      while (txd !== 1'b0 && waited < 4 * CPB) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("ffTxStart", 32'(txd), 32'h0);
      repeat (5 * CPB) @(negedge clk);
      rst = 1'b0;
      resetEpoch++;
      #1;
      checkOutput("midTxTxd", 32'(txd), 32'h1);
      checkOutput("midTxLed", 32'(ledBus), 32'h00);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      refBase = 0;
      refAnchor = cyc;
      fallsBefore = txFalls;
      repeat (15 * CPB) @(negedge clk);
      checkOutput("noLeftoverFrame", txFalls, fallsBefore);
      checkOutput("noLeftoverByte", txQueue.size(), 0);
      checkLed("ledAfterReset");
      checkOutput("txFrameErrors", txBad, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
